// File: rtl/memory_unit.sv
// -----------------------------------------------------------------------------
// memory_unit
// Bus responder for the tiny16 datapath. It holds a 16-bit address register,
// a word-addressed RAM and a small memory-mapped I/O page at 0xFFF0-0xFFFF:
//   0xFFF0 TX_DATA : write pushes in[7:0] into the TX FIFO (dropped when full)
//   0xFFF1 STATUS  : {11'b0, rx_ovr, rx_full, tx_ovf, tx_full, tx_empty},
//                    write-1-to-clear of tx_ovf (in[2]) and rx_ovr (in[4])
//   0xFFF2 RX_DATA : read returns {8'b0, rx_buf} and clears rx_full
//   others         : read 0, writes ignored
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   mem_addr_en  load the address register from `in`
//   mem_in_en    write `in` to the addressed location
//   mem_out_en   drive the addressed location onto `out` (else out = 0)
//   in / out     16-bit bus toward / from memory (`out` is combinational)
//   tx_data      head byte of the TX FIFO
//   tx_valid     TX FIFO not empty
//   tx_ready     consumer accepts the head byte
//   rx_data      external input byte
//   rx_strobe    one-cycle pulse capturing rx_data into the RX register
// -----------------------------------------------------------------------------
module memory_unit #(
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_addr_en,
   input  logic        mem_in_en,
   input  logic        mem_out_en,
   input  logic [15:0] in,
   output logic [15:0] out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_strobe
);

   localparam int RAM_WORDS = 1 << ADDR_WIDTH;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;

   localparam logic [3:0] REG_TX_DATA = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h1;
   localparam logic [3:0] REG_RX_DATA = 4'h2;

   // Registers
   logic [15:0]           r_addr;
   logic [15:0]           r_ram [0:RAM_WORDS-1];
   logic [7:0]            r_fifo [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_tx_ovf;
   logic                  r_rx_full;
   logic                  r_rx_ovr;
   logic [7:0]            r_rx_buf;

   // Decode and control wires
   logic                  w_is_io;
   logic [3:0]            w_io_sel;
   logic [ADDR_WIDTH-1:0] w_ram_idx;
   logic                  w_tx_full;
   logic                  w_tx_empty;
   logic                  w_push_req;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_status_wr;
   logic                  w_rx_rd;
   logic                  w_ovf_set;
   logic                  w_ovr_set;
   logic [15:0]           w_status;
   logic [15:0]           w_io_rdata;

   // Address decode and strobe qualification; every access uses the current r_addr
   always_comb begin
      w_is_io     = (r_addr[15:4] == 12'hFFF);
      w_io_sel    = r_addr[3:0];
      w_ram_idx   = r_addr[ADDR_WIDTH-1:0];
      w_tx_full   = (r_count == CNT_W'(FIFO_DEPTH));
      w_tx_empty  = (r_count == {CNT_W{1'b0}});
      w_push_req  = mem_in_en && w_is_io && (w_io_sel == REG_TX_DATA);
      // Fullness is judged before any pop in the same edge, so a push into a
      // full FIFO is dropped even when the consumer is draining.
      w_push      = w_push_req && !w_tx_full;
      w_ovf_set   = w_push_req && w_tx_full;
      w_pop       = !w_tx_empty && tx_ready;
      w_status_wr = mem_in_en && w_is_io && (w_io_sel == REG_STATUS);
      w_rx_rd     = mem_out_en && w_is_io && (w_io_sel == REG_RX_DATA);
      // A read-clear coinciding with a new byte is not an overrun.
      w_ovr_set   = rx_strobe && r_rx_full && !w_rx_rd;
   end

   // Address register load
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= 16'h0000;
      end else if (mem_addr_en) begin
         r_addr <= in;
      end
   end

   // RAM write port; contents intentionally survive reset
   always_ff @(posedge clk) begin
      if (mem_in_en && !w_is_io) begin
         r_ram[w_ram_idx] <= in;
      end
   end

   // TX FIFO storage, pointers and occupancy count
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo[i] <= 8'h00;
         end
         r_rd_ptr <= {PTR_W{1'b0}};
         r_wr_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= in[7:0];
            r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky flags and RX holding register; a set event beats a W1C clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_ovf  <= 1'b0;
         r_rx_full <= 1'b0;
         r_rx_ovr  <= 1'b0;
         r_rx_buf  <= 8'h00;
      end else begin
         if (w_ovf_set) begin
            r_tx_ovf <= 1'b1;
         end else if (w_status_wr && in[2]) begin
            r_tx_ovf <= 1'b0;
         end

         if (rx_strobe) begin
            r_rx_buf  <= rx_data;
            r_rx_full <= 1'b1;
         end else if (w_rx_rd) begin
            r_rx_full <= 1'b0;
         end

         if (w_ovr_set) begin
            r_rx_ovr <= 1'b1;
         end else if (w_status_wr && in[4]) begin
            r_rx_ovr <= 1'b0;
         end
      end
   end

   // Combinational read mux; shows pre-write data when a write is in the same cycle
   always_comb begin
      w_status = {11'b000_0000_0000, r_rx_ovr, r_rx_full, r_tx_ovf, w_tx_full, w_tx_empty};
      case (w_io_sel)
         REG_STATUS:  w_io_rdata = w_status;
         REG_RX_DATA: w_io_rdata = {8'h00, r_rx_buf};
         default:     w_io_rdata = 16'h0000;
      endcase
      if (!mem_out_en) begin
         out = 16'h0000;
      end else if (w_is_io) begin
         out = w_io_rdata;
      end else begin
         out = r_ram[w_ram_idx];
      end
   end

   // TX head presentation
   always_comb begin
      tx_valid = !w_tx_empty;
      tx_data  = r_fifo[r_rd_ptr];
   end

endmodule

// File: doc/memory_unit.md
# memory_unit

Bus responder for the tiny16 datapath: it acts on the `mem_addr_en`, `mem_in_en` and `mem_out_en` strobes the controller issues. It holds an address register and a word-addressed RAM. A memory-mapped I/O page at 0xFFF0–0xFFFF provides a byte TX FIFO with valid/ready output and a single-entry RX holding register with sticky error flags.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: RAM holds 2^ADDR_WIDTH 16-bit words, indexed by the low ADDR_WIDTH bits of the address register.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock. One clock domain; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_addr_en`  in  1  load the address register from `in`.
- `mem_in_en`  in  1  write `in` to the currently addressed location.
- `mem_out_en`  in  1  drive the addressed location onto `out`.
- `in`  in  16  bus data toward memory.
- `out`  out  16  bus data from memory.
- `tx_data`  out  8  head byte of the TX FIFO.
- `tx_valid`  out  1  TX FIFO not empty.
- `tx_ready`  in  1  consumer accepts the head byte.
- `rx_data`  in  8  external input byte.
- `rx_strobe`  in  1  one-cycle pulse: capture `rx_data`.

## Operation
- Address register `addr` (16 b): when `mem_addr_en`=1 at an edge, `addr` <= `in`.
- Address decode uses full 16-bit `addr`:
  - I/O when `addr[15:4]`==12'hFFF.
  - RAM otherwise; high bits are ignored, so RAM aliases.
- RAM write: when `mem_in_en`=1 at an edge and `addr` is RAM, `ram[addr[ADDR_WIDTH-1:0]]` <= `in`.
- Read path: `out` is combinational.
  - RAM address: `ram[addr]` while `mem_out_en`=1; 0 while `mem_out_en`=0.
- I/O map:
  - 0xFFF0 TX_DATA.
    - Write pushes `in[7:0]` when the FIFO is not full.
    - When full, the byte is dropped and `tx_ovf` is set.
    - Reads return 0.
  - 0xFFF1 STATUS.
    - Read: {11'b0, rx_ovr, rx_full, tx_ovf, tx_full, tx_empty}, bits 4..0.
    - Write is write-1-to-clear: `in[2]` clears `tx_ovf`; `in[4]` clears `rx_ovr`. Other bits are ignored.
  - 0xFFF2 RX_DATA.
    - Read returns {8'b0, rx_buf}.
    - An edge with `mem_out_en`=1 at this address clears `rx_full`.
    - Writes are ignored.
  - 0xFFF3–0xFFFF: read 0, writes ignored.
- TX FIFO: circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - `tx_valid` = (count≠0).
  - `tx_data` = mem[rd_ptr].
  - Pop when `tx_valid`&&`tx_ready` at an edge.
  - Pointers wrap modulo FIFO_DEPTH.
- RX:
  - `rx_strobe` loads `rx_buf` <= `rx_data` and sets `rx_full`.
  - If `rx_full` was already 1 and is not being cleared in the same edge, `rx_ovr` is also set; the new byte overwrites.

Boundary rules (all decided):
- `mem_addr_en` together with `mem_in_en`/`mem_out_en`: the access uses the old `addr`; the new address takes effect next cycle.
- `mem_in_en` together with `mem_out_en`: `out` shows pre-write data; the write commits at the edge.
- Push on full in the same edge as a pop: fullness is evaluated before the pop, so the push is dropped, `tx_ovf` is set, and the pop proceeds.
- Push on empty: `tx_valid` rises the next cycle; no fall-through.
- RX read-clear together with `rx_strobe`: the new byte is stored, `rx_full` stays 1, and `rx_ovr` is unchanged.
- Status W1C together with a flag-setting event: set wins.
- Reset:
  - `addr`=0; FIFO pointers and count 0; `tx_ovf`=`rx_full`=`rx_ovr`=0; `rx_buf`=0.
  - `tx_valid`=0; `tx_data`=0 (FIFO storage reset to 0); `out`=0 unless `mem_out_en`.
  - RAM contents are not reset.
  - Reset mid-transfer discards all FIFO contents.

## Timing
- Address load: 1 edge. Data reads are valid in the same cycle `mem_out_en` is high, i.e. the cycle after `addr` was loaded.
- RAM write: committed at the edge; readable in the next cycle.
- TX: a byte pushed at edge N appears on `tx_valid`/`tx_data` after edge N. Throughput is one pop per cycle.
- Status bits update at the edge after the causing event and are visible combinationally on STATUS reads.
- No wait states: every access completes in the cycle its strobe is high, matching the controller's fixed-step sequencing.

## Test plan
- RAM round trip: load addr 0x0012, write 0xBEEF, load addr 0x0012, read -> `out`=0xBEEF. Read 0x0112 (alias, ADDR_WIDTH=8) -> 0xBEEF.
- TX fill/overflow: with `tx_ready`=0, write 0x41,0x42,0x43,0x44,0x45 to 0xFFF0 -> STATUS=0x0006. Raise `tx_ready` -> 0x41..0x44 emerge in order, then `tx_valid`=0 and STATUS=0x0005.
- Full push with simultaneous pop: FIFO full, `tx_ready`=1, write 0x99 -> byte dropped, `tx_ovf`=1, count=3 after the edge. W1C 0x0004 -> STATUS bit2=0.
- RX: strobe 0x5A -> STATUS bit3=1; read 0xFFF2 -> 0x005A, then bit3=0. Two strobes without a read -> `rx_ovr`=1 and the second byte is kept.
- Reset mid-operation: FIFO holding 2 bytes and `rx_full`=1, assert `rst` one cycle -> `tx_valid`=0, STATUS=0x0001, `addr`=0. RAM word written earlier is still readable.
